// File: rtl/seq_w_tx_pkg.sv
// Shared types and defaults for the serial w-stimulus transmitter.
package seq_w_tx_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_LEN_W  = 4;
    localparam int unsigned DEF_HOLD_W = 4;
    localparam int unsigned DEF_REP_W  = 4;

    // Level driven on w whenever no pattern bit is being sent.
    localparam logic W_IDLE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_w_hold_ctr.sv
// Loadable down-counter timing how long each serial bit is held.
module seq_w_hold_ctr #(
    parameter int unsigned HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [HOLD_W-1:0] val_i,
    output logic              zero_o
);

    logic [HOLD_W-1:0] cnt_q;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_w_tx.sv
// Serial stimulus transmitter: sends a latched pattern MSB-first on w,
// each bit held hold+1 cycles, repeated rep+1 times, then pulses done.
module seq_w_tx
    import seq_w_tx_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned HOLD_W = DEF_HOLD_W,
    parameter int unsigned REP_W  = DEF_REP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    input  logic [LEN_W-1:0]  len,
    input  logic [HOLD_W-1:0] hold,
    input  logic [REP_W-1:0]  rep,
    output logic              w,
    output logic              valid,
    output logic              ready,
    output logic              done
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   pat_q,   pat_d;
    logic [LEN_W-1:0]    len_q,   len_d;
    logic [LEN_W-1:0]    idx_q,   idx_d;
    logic [HOLD_W-1:0]   hold_q,  hold_d;
    logic [REP_W-1:0]    rep_q,   rep_d;

    logic [LEN_W-1:0]    len_clamped;
    logic [DATA_W-1:0]   pat_shift;
    logic                hc_load;
    logic                hc_en;
    logic [HOLD_W-1:0]   hc_val;
    logic                hc_zero;

    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;

    // Shift rather than index so the LEN_W-wide idx never over-indexes pat_q.
    assign pat_shift = pat_q >> idx_q;

    seq_w_hold_ctr #(
        .HOLD_W (HOLD_W)
    ) u_hold_ctr (
        .clk    (clk),
        .rst    (rst),
        .load_i (hc_load),
        .en_i   (hc_en),
        .val_i  (hc_val),
        .zero_o (hc_zero)
    );

    // State and transfer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
        end
    end

    // Next-state, counter control and latching of the request.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        hc_load = 1'b0;
        hc_en   = 1'b0;
        hc_val  = hold_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    len_d   = len_clamped;
                    hold_d  = hold;
                    rep_d   = rep;
                    hc_load = 1'b1;
                    hc_val  = hold;
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                        idx_d   = len_clamped - 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (!hc_zero) begin
                    hc_en = 1'b1;
                end else begin
                    hc_load = 1'b1;
                    if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                    end else if (rep_q != '0) begin
                        rep_d = rep_q - 1'b1;
                        idx_d = len_q - 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign w     = (state_q == SHIFT) ? pat_shift[0] : W_IDLE;
    assign valid = (state_q == SHIFT);
    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_seq_w_tx.sv
// Directed self-checking bench for seq_w_tx.
module tb_seq_w_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] hold;
    logic [3:0] rep;
    logic       w;
    logic       valid;
    logic       ready;
    logic       done;

    int errors = 0;
    int checks = 0;

    seq_w_tx #(
        .DATA_W (8),
        .LEN_W  (4),
        .HOLD_W (4),
        .REP_W  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .hold    (hold),
        .rep     (rep),
        .w       (w),
        .valid   (valid),
        .ready   (ready),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller sits at a negedge. Waits (bounded) until ready is high.
    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: ready=%b required 1 after %0d cycles", ready, n);
        end
    endtask

    // Caller sits at a negedge with ready=1. Returns #1 after edge 0 with
    // start dropped and the inputs scrambled, so they must have been latched.
    task automatic start_xfer(input logic [7:0] p, input logic [3:0] l,
                              input logic [3:0] h, input logic [3:0] r);
        pattern = p;
        len     = l;
        hold    = h;
        rep     = r;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        pattern = ~p;
        len     = 4'd1;
        hold    = 4'd7;
        rep     = 4'd3;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pattern = '0; len = '0; hold = '0; rep = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({w, valid, ready, done} !== 4'b0010) begin
            errors++;
            $display("FAIL reset: w/valid/ready/done=%b required 0010", {w, valid, ready, done});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [2:0] exp_w = 3'b010;
        wait_ready();
        start_xfer(8'b0000_0010, 4'd3, 4'd0, 4'd0);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            checks++;
            if ({w, valid, ready, done} !== {exp_w[3-cyc], 3'b100}) begin
                errors++;
                $display("FAIL basic cycle %0d: w/valid/ready/done=%b required %b",
                         cyc, {w, valid, ready, done}, {exp_w[3-cyc], 3'b100});
            end
        end
        @(negedge clk);
        checks++;
        if ({w, valid, ready, done} !== 4'b0001) begin
            errors++;
            $display("FAIL basic done cycle 4: w/valid/ready/done=%b required 0001", {w, valid, ready, done});
        end
        @(negedge clk);
        checks++;
        if ({ready, done} !== 2'b10) begin
            errors++;
            $display("FAIL basic ready cycle 5: ready/done=%b required 10", {ready, done});
        end
    endtask

    task automatic test_hold();
        logic [8:0] exp_w = 9'b000_111_000;
        wait_ready();
        start_xfer(8'b0000_0010, 4'd3, 4'd2, 4'd0);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            checks++;
            if ({w, valid, done} !== {exp_w[9-cyc], 2'b10}) begin
                errors++;
                $display("FAIL hold cycle %0d: w/valid/done=%b required %b",
                         cyc, {w, valid, done}, {exp_w[9-cyc], 2'b10});
            end
        end
        @(negedge clk);
        checks++;
        if ({valid, done} !== 2'b01) begin
            errors++;
            $display("FAIL hold done cycle 10: valid/done=%b required 01", {valid, done});
        end
    endtask

    task automatic test_repeat();
        logic [5:0] exp_w = 6'b101010;
        wait_ready();
        start_xfer(8'b0000_0010, 4'd2, 4'd0, 4'd2);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            checks++;
            if ({w, valid, done} !== {exp_w[6-cyc], 2'b10}) begin
                errors++;
                $display("FAIL repeat cycle %0d: w/valid/done=%b required %b",
                         cyc, {w, valid, done}, {exp_w[6-cyc], 2'b10});
            end
        end
        @(negedge clk);
        checks++;
        if ({w, valid, done} !== 3'b001) begin
            errors++;
            $display("FAIL repeat done cycle 7: w/valid/done=%b required 001", {w, valid, done});
        end
    endtask

    task automatic test_len_zero();
        wait_ready();
        start_xfer(8'hFF, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        checks++;
        if ({w, valid, ready, done} !== 4'b0001) begin
            errors++;
            $display("FAIL len0 cycle 1: w/valid/ready/done=%b required 0001", {w, valid, ready, done});
        end
        @(negedge clk);
        checks++;
        if ({w, valid, ready, done} !== 4'b0010) begin
            errors++;
            $display("FAIL len0 cycle 2: w/valid/ready/done=%b required 0010", {w, valid, ready, done});
        end
    endtask

    task automatic test_clamp();
        logic [7:0] exp_w = 8'hA5;
        wait_ready();
        start_xfer(8'hA5, 4'd12, 4'd0, 4'd0);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            checks++;
            if ({w, valid, done} !== {exp_w[8-cyc], 2'b10}) begin
                errors++;
                $display("FAIL clamp cycle %0d: w/valid/done=%b required %b",
                         cyc, {w, valid, done}, {exp_w[8-cyc], 2'b10});
            end
        end
        @(negedge clk);
        checks++;
        if ({valid, done} !== 2'b01) begin
            errors++;
            $display("FAIL clamp done cycle 9: valid/done=%b required 01", {valid, done});
        end
    endtask

    task automatic test_busy_start();
        wait_ready();
        start_xfer(8'hFF, 4'd8, 4'd0, 4'd0);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 4) start = 1'b0;
            checks++;
            if ({w, valid, ready} !== 3'b110) begin
                errors++;
                $display("FAIL busy cycle %0d: w/valid/ready=%b required 110", cyc, {w, valid, ready});
            end
            if (cyc == 3) begin
                pattern = 8'h00;
                len     = 4'd2;
                start   = 1'b1;
            end
        end
        @(negedge clk);
        checks++;
        if ({valid, done} !== 2'b01) begin
            errors++;
            $display("FAIL busy done cycle 9: valid/done=%b required 01", {valid, done});
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({valid, ready} !== 2'b01) begin
            errors++;
            $display("FAIL busy no-queue cycle 11: valid/ready=%b required 01", {valid, ready});
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done = 1'b0;
        wait_ready();
        start_xfer(8'hFF, 4'd8, 4'd0, 4'd0);
        repeat (4) @(negedge clk);
        checks++;
        if ({w, valid} !== 2'b11) begin
            errors++;
            $display("FAIL abort pre-reset cycle 4: w/valid=%b required 11", {w, valid});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({w, valid, ready, done} !== 4'b0010) begin
            errors++;
            $display("FAIL abort async reset: w/valid/ready/done=%b required 0010", {w, valid, ready, done});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (done !== 1'b0 || valid !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort residue: done/valid seen=%b required 0", saw_done);
        end
        wait_ready();
        start_xfer(8'h01, 4'd1, 4'd0, 4'd0);
        @(negedge clk);
        checks++;
        if ({w, valid} !== 2'b11) begin
            errors++;
            $display("FAIL abort restart cycle 1: w/valid=%b required 11", {w, valid});
        end
        @(negedge clk);
        checks++;
        if ({w, valid, done} !== 3'b001) begin
            errors++;
            $display("FAIL abort restart cycle 2: w/valid/done=%b required 001", {w, valid, done});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_v = 4'b1001;
        wait_ready();
        pattern = 8'h01; len = 4'd1; hold = 4'd0; rep = 4'd0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            checks++;
            if (valid !== exp_v[4-cyc] || (valid === 1'b1 && w !== 1'b1)) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: valid=%b w=%b required valid=%b w=1",
                         cyc, valid, w, exp_v[4-cyc]);
            end
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back done cycle 5: done=%b required 1", done);
        end
        @(negedge clk);
        checks++;
        if ({ready, valid} !== 2'b10) begin
            errors++;
            $display("FAIL back_to_back idle cycle 6: ready/valid=%b required 10", {ready, valid});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_repeat();
        test_len_zero();
        test_clamp();
        test_busy_start();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
